fp_op_sched: RTL
================

# fp_op_sched

Two-requester scheduler that shares one `fpaddsub_32b` and one `fpmul_32b` instance between two independent operand sources. It arbitrates round-robin and decodes the operation onto the shared units. It bypasses zero operands around the adder, which has no zero handling. Results go into a single registered output slot tagged with the requester ID. The block sits between the FP command sources and the result consumer and is the only path into the shared arithmetic units.

## Interface
Parameters:
- `M`, default 8: exponent width.
- `N`, default 23: mantissa width; operand/result width is M+N+1.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req0_valid`, `req1_valid`  in  1  requester i presents an operation.
- `req0_ready`, `req1_ready`  out  1  requester i's operation is accepted this cycle.
- `req0_op`, `req1_op`  in  2  operation code: 00 add, 01 sub, 10 mul, 11 illegal.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  M+N+1  IEEE-style operands.
- `res_valid`  out  1  output slot holds a result.
- `res_ready`  in  1  consumer takes the result this cycle.
- `res_data`  out  M+N+1  result.
- `res_id`  out  1  requester that issued the result.
- `res_err`  out  1  the operation was illegal (op 11).

## Operation
- `slot_free` = !res_valid || res_ready.
- Grant logic:
  - `grant_i` = req_i_valid && (other requester idle || rr_ptr favours i).
  - `rr_ptr` points at the requester that won the last tie-free grant. On a tie, the requester not equal to `rr_ptr` wins.
  - `req_i_ready` = slot_free && grant_i. At most one ready is high per cycle.
- On accept (valid && ready), the granted operands are muxed to both units:
  - `sub` is driven as op==01.
  - add/sub selects the adder output; mul selects the multiplier output.
- Zero bypass (add/sub only). An operand is zero when bits [M+N-1:0]==0. b_eff is b with its sign XORed with `sub`.
  - a zero, b nonzero: result = b_eff.
  - b zero, a nonzero: result = a.
  - both zero: result = {a_sign & b_eff_sign, all zeros}.
- Mul zero handling is left to the multiplier.
- Illegal op: result 0 and `res_err`=1. The op is still consumed and still advances `rr_ptr`.
- On accept, `rr_ptr` is updated to the granted ID.
- The accepting cycle loads `res_data`/`res_id`/`res_err` and sets `res_valid`.
- When `res_ready` && `res_valid` and there is no accept, `res_valid` clears.
- Denormals, NaN, Inf and rounding are passed through as the units produce them; the block does no checking.

## Timing
- Reset values while `rst_n`=0 at a clock edge:
  - `res_valid`=0, `res_data`=0, `res_id`=0, `res_err`=0.
  - `rr_ptr`=1, so requester 0 wins the first tie.
  - Both `req_i_ready`=0 while `rst_n` is low.
- Latency: accept in cycle T gives `res_valid`=1 with the result in cycle T+1.
- Throughput: one result per cycle while `res_ready` is held high. Accept and drain in the same cycle keeps `res_valid` high with new data.
- Backpressure: while `res_valid` && !`res_ready`, `res_data`, `res_id` and `res_err` are held stable, both readies are 0, and `rr_ptr` is frozen.
- Requester rules:
  - Once `req_i_valid` is asserted, it must stay high with stable operands until accepted.
  - `req_i_ready` may depend on the valid inputs; valid must not depend on ready.
- Reset during a held result discards the result; the next cycle shows `res_valid`=0.

## Structure
- Package `fp_sched_pkg`:
  - op-code localparams `OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_ILL`;
  - defaults M=8 and N=23;
  - an `is_zero` function.
- Sub-module `fp_rr_arb2`: 2-way round-robin grant plus `rr_ptr` register, with inputs valid[1:0], slot_free and accept.
- The top level instantiates `fp_rr_arb2`, one `fpaddsub_32b` and one `fpmul_32b`, and contains the operand mux, zero bypass and output register.

## Test plan
- Single add: req0 add 0x3F800000 + 0x40000000 with `res_ready`=1 → next cycle `res_valid`=1, `res_data`=0x40400000, `res_id`=0, `res_err`=0.
- Tie: after reset, both requesters valid in the same cycle. Req0 is mul 0x3FC00000 × 0x40000000; req1 is sub 0x40400000 − 0x3F800000. Expected: 0x40400000/id0 first, then 0x40000000/id1 the next cycle. A further tie then grants req0.
- Backpressure: hold `res_ready`=0 for 3 cycles with both requesters valid → `res_data` stable, both readies 0. Release → drain and new accept happen in the same cycle.
- Zero bypass:
  - add 0x00000000 + 0xC0000000 → 0xC0000000;
  - sub 0x3F800000 − 0x00000000 → 0x3F800000;
  - sub 0x00000000 − 0x00000000 → 0x00000000.
- Illegal op: req1 op 11 → `res_data`=0, `res_err`=1, `res_id`=1, and req1 is accepted exactly once.
- Reset mid-hold: with `res_valid`=1 and `res_ready`=0, pulse `rst_n`=0 for one cycle → `res_valid`=0. The next tie grants req0.

Source files
------------

// File: rtl/fp_sched_pkg.sv
// Shared constants for the FP operation scheduler: op codes, default
// field widths and the zero-operand test used by the bypass and multiplier.
package fp_sched_pkg;

  localparam int FP_M = 8;
  localparam int FP_N = 23;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  // Caller passes exponent+mantissa bits zero-extended; sign is ignored.
  function automatic logic is_zero(input logic [63:0] mag);
    return (mag == 64'd0);
  endfunction

endpackage

// File: rtl/fp_rr_arb2.sv
// Two-way round-robin arbiter. rr_q holds the last accepted requester, so a
// tie goes to the other one; the pointer only moves on an accepted grant.
module fp_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid_i,
  input  logic       slot_free_i,
  input  logic       accept_i,
  output logic [1:0] ready_o,
  output logic       gnt_id_o
);

  logic       rr_q;
  logic       rr_d;
  logic [1:0] grant_s;

  always_comb begin
    grant_s[0] = valid_i[0] && (!valid_i[1] || rr_q);
    grant_s[1] = valid_i[1] && (!valid_i[0] || !rr_q);
    gnt_id_o   = grant_s[1];
    if (rst_n && slot_free_i) begin
      ready_o = grant_s;
    end else begin
      ready_o = 2'b00;
    end
    if (accept_i) begin
      rr_d = grant_s[1];
    end else begin
      rr_d = rr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q <= 1'b1;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/fpaddsub_32b.sv
// Combinational FP adder/subtractor with truncation. No zero, NaN or Inf
// handling: those cases pass through whatever the datapath produces.
module fpaddsub_32b #(
  parameter int M = 8,
  parameter int N = 23
) (
  input  logic [M+N:0] a_i,
  input  logic [M+N:0] b_i,
  input  logic         sub_i,
  output logic [M+N:0] y_o
);

  localparam int W  = M + N + 1;
  localparam int MW = N + 4;
  localparam int SW = N + 5;

  logic          sa_s, sb_s, s_big_s, a_big_s;
  logic [M-1:0]  ea_s, eb_s, e_big_s, e_sml_s, e_res_s, sh_m_s;
  logic [MW-1:0] ma_s, mb_s, m_big_s, m_sml_s, m_al_s;
  logic [SW-1:0] sum_s, norm_s;
  int            lead_s;

  // Order operands by magnitude so the subtraction never goes negative.
  always_comb begin
    sa_s    = a_i[W-1];
    sb_s    = b_i[W-1] ^ sub_i;
    ea_s    = a_i[W-2:N];
    eb_s    = b_i[W-2:N];
    ma_s    = {|ea_s, a_i[N-1:0], 3'b000};
    mb_s    = {|eb_s, b_i[N-1:0], 3'b000};
    a_big_s = (a_i[W-2:0] >= b_i[W-2:0]);
    if (a_big_s) begin
      e_big_s = ea_s;
      e_sml_s = eb_s;
      m_big_s = ma_s;
      m_sml_s = mb_s;
      s_big_s = sa_s;
    end else begin
      e_big_s = eb_s;
      e_sml_s = ea_s;
      m_big_s = mb_s;
      m_sml_s = ma_s;
      s_big_s = sb_s;
    end
    m_al_s = m_sml_s >> (e_big_s - e_sml_s);
  end

  always_comb begin
    if (sa_s == sb_s) begin
      sum_s = {1'b0, m_big_s} + {1'b0, m_al_s};
    end else begin
      sum_s = {1'b0, m_big_s} - {1'b0, m_al_s};
    end
    lead_s = 0;
    for (int i = 0; i < SW; i++) begin
      if (sum_s[i]) begin
        lead_s = i;
      end
    end
    norm_s  = '0;
    e_res_s = '0;
    sh_m_s  = '0;
    if (sum_s == '0) begin
      y_o = '0;
    end else if (lead_s == SW - 1) begin
      norm_s  = sum_s >> 1;
      e_res_s = e_big_s + M'(1);
      y_o     = {s_big_s, e_res_s, N'(norm_s >> 3)};
    end else begin
      sh_m_s  = M'(SW - 2 - lead_s);
      norm_s  = sum_s << (SW - 2 - lead_s);
      e_res_s = e_big_s - sh_m_s;
      y_o     = {s_big_s, e_res_s, N'(norm_s >> 3)};
    end
  end

endmodule

// File: rtl/fpmul_32b.sv
// Combinational FP multiplier with truncation. A zero operand yields a zero
// carrying the XOR of the signs; other specials pass through unchecked.
module fpmul_32b
  import fp_sched_pkg::*;
#(
  parameter int M = 8,
  parameter int N = 23
) (
  input  logic [M+N:0] a_i,
  input  logic [M+N:0] b_i,
  output logic [M+N:0] y_o
);

  localparam int W  = M + N + 1;
  localparam int PW = 2 * N + 2;
  localparam logic [M+1:0] BIAS = (M+2)'((1 << (M - 1)) - 1);

  logic          s_s;
  logic [M-1:0]  ea_s, eb_s;
  logic [N:0]    ma_s, mb_s;
  logic [PW-1:0] p_s;
  logic [M+1:0]  e_s;

  always_comb begin
    s_s  = a_i[W-1] ^ b_i[W-1];
    ea_s = a_i[W-2:N];
    eb_s = b_i[W-2:N];
    ma_s = {|ea_s, a_i[N-1:0]};
    mb_s = {|eb_s, b_i[N-1:0]};
    p_s  = PW'(ma_s) * PW'(mb_s);
    e_s  = (M+2)'(ea_s) + (M+2)'(eb_s) - BIAS;
    if (is_zero(64'(a_i[W-2:0])) || is_zero(64'(b_i[W-2:0]))) begin
      y_o = {s_s, {(W-1){1'b0}}};
    end else if (p_s[PW-1]) begin
      y_o = {s_s, M'(e_s + (M+2)'(1)), N'(p_s >> (N + 1))};
    end else begin
      y_o = {s_s, M'(e_s), N'(p_s >> N)};
    end
  end

endmodule

// File: rtl/fp_op_sched.sv
// Two-requester scheduler sharing one FP adder and one FP multiplier, with a
// zero bypass around the adder and a single registered result slot.
module fp_op_sched
  import fp_sched_pkg::*;
#(
  parameter int M = FP_M,
  parameter int N = FP_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [1:0]   req0_op,
  input  logic [M+N:0] req0_a,
  input  logic [M+N:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [1:0]   req1_op,
  input  logic [M+N:0] req1_a,
  input  logic [M+N:0] req1_b,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [M+N:0] res_data,
  output logic         res_id,
  output logic         res_err
);

  localparam int W = M + N + 1;

  logic [1:0]   ready_s;
  logic         gnt_id_s, slot_free_s, accept_s, sub_s;
  logic         a_zero_s, b_zero_s;
  logic [1:0]   op_s;
  logic [W-1:0] a_s, b_s, b_eff_s, add_y_s, mul_y_s;
  logic [W-1:0] data_d;
  logic         err_d;
  logic         valid_q, id_q, err_q;
  logic [W-1:0] data_q;

  assign slot_free_s = !valid_q || res_ready;
  assign accept_s    = (req0_valid && ready_s[0]) || (req1_valid && ready_s[1]);
  assign req0_ready  = ready_s[0];
  assign req1_ready  = ready_s[1];

  fp_rr_arb2 u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_i     ({req1_valid, req0_valid}),
    .slot_free_i (slot_free_s),
    .accept_i    (accept_s),
    .ready_o     (ready_s),
    .gnt_id_o    (gnt_id_s)
  );

  always_comb begin
    if (gnt_id_s) begin
      op_s = req1_op;
      a_s  = req1_a;
      b_s  = req1_b;
    end else begin
      op_s = req0_op;
      a_s  = req0_a;
      b_s  = req0_b;
    end
    sub_s = (op_s == OP_SUB);
  end

  fpaddsub_32b #(.M(M), .N(N)) u_add (
    .a_i   (a_s),
    .b_i   (b_s),
    .sub_i (sub_s),
    .y_o   (add_y_s)
  );

  fpmul_32b #(.M(M), .N(N)) u_mul (
    .a_i (a_s),
    .b_i (b_s),
    .y_o (mul_y_s)
  );

  // The adder cannot handle zero operands, so those results are formed here.
  always_comb begin
    data_d   = '0;
    err_d    = 1'b0;
    b_eff_s  = {b_s[W-1] ^ sub_s, b_s[W-2:0]};
    a_zero_s = is_zero(64'(a_s[W-2:0]));
    b_zero_s = is_zero(64'(b_s[W-2:0]));
    case (op_s)
      OP_ADD, OP_SUB: begin
        if (a_zero_s && b_zero_s) begin
          data_d = {a_s[W-1] & b_eff_s[W-1], {(W-1){1'b0}}};
        end else if (a_zero_s) begin
          data_d = b_eff_s;
        end else if (b_zero_s) begin
          data_d = a_s;
        end else begin
          data_d = add_y_s;
        end
      end
      OP_MUL: begin
        data_d = mul_y_s;
      end
      default: begin
        data_d = '0;
        err_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept_s) begin
      valid_q <= 1'b1;
      data_q  <= data_d;
      id_q    <= gnt_id_s;
      err_q   <= err_d;
    end else if (res_ready) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_q;
    end
  end

  assign res_valid = valid_q;
  assign res_data  = data_q;
  assign res_id    = id_q;
  assign res_err   = err_q;

endmodule
